// File: rtl/esdi_cmd_sequencer.sv
// ESDI command sequencer: shifts a 16-bit command plus odd parity out over the
// req/ack handshake, optionally collects status words, and reports completion.
module esdi_cmd_sequencer #(
    parameter int unsigned DATA_SETUP  = 6,
    parameter int unsigned ACK_TO_NREQ = 6,
    parameter int unsigned BIT_TIMEOUT = 1_000_000
) (
    input  logic        csr_aclk,
    input  logic        csr_areset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_word,
    input  logic [1:0]  cmd_nstat,
    output logic        stat_valid,
    output logic [15:0] stat_word,
    output logic        stat_perr,
    output logic        done,
    output logic [1:0]  err,
    output logic        attention,
    output logic        esdi_transfer_req,
    output logic        esdi_command_data,
    input  logic        esdi_transfer_ack,
    input  logic        esdi_confstat_data,
    input  logic        esdi_command_complete,
    input  logic        esdi_attention
);

    localparam int unsigned FRAME_W = 17;
    localparam int unsigned BITS_W  = 5;
    localparam int unsigned DLY_MAX = (DATA_SETUP > ACK_TO_NREQ) ? DATA_SETUP : ACK_TO_NREQ;
    localparam int unsigned CNT_MAX = (BIT_TIMEOUT > DLY_MAX) ? BIT_TIMEOUT : DLY_MAX;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_REQ, S_HOLD, S_NACK,
        S_SREQ, S_SHOLD, S_SNACK, S_WCC, S_FIN
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [FRAME_W-1:0]   stat_sh_q, stat_sh_d;
    logic [BITS_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]           words_q, words_d;
    logic [3:0]           sync1_q, sync1_d, sync2_q, sync2_d;
    logic                 req_q, req_d;
    logic                 data_q, data_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 stat_valid_q, stat_valid_d;
    logic [15:0]          stat_word_q, stat_word_d;
    logic                 stat_perr_q, stat_perr_d;
    logic                 done_q, done_d;
    logic [1:0]           err_q, err_d;
    logic                 ack_s, confstat_s, complete_s, timeout;

    assign ack_s      = sync2_q[0];
    assign confstat_s = sync2_q[1];
    assign complete_s = sync2_q[2];
    assign timeout    = (cnt_q == CNT_W'(BIT_TIMEOUT - 1));

    // Next-state, datapath and registered-output logic
    always_comb begin
        sync1_d      = {esdi_attention, esdi_command_complete, esdi_confstat_data, esdi_transfer_ack};
        sync2_d      = sync1_q;
        state_d      = state_q;
        shift_d      = shift_q;
        stat_sh_d    = stat_sh_q;
        bit_cnt_d    = bit_cnt_q;
        words_d      = words_q;
        stat_valid_d = 1'b0;
        stat_word_d  = stat_word_q;
        stat_perr_d  = stat_perr_q;
        done_d       = 1'b0;
        err_d        = err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    shift_d   = {cmd_word, ~^cmd_word};
                    words_d   = cmd_nstat;
                    bit_cnt_d = '0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: if (cnt_q == CNT_W'(DATA_SETUP - 1)) state_d = S_REQ;
            S_REQ: begin
                if (ack_s) state_d = S_HOLD;
                else if (timeout) begin
                    state_d = S_IDLE; done_d = 1'b1; err_d = 2'd1;
                end
            end
            S_HOLD: if (cnt_q == CNT_W'(ACK_TO_NREQ - 1)) state_d = S_NACK;
            S_NACK: begin
                if (!ack_s) begin
                    if (bit_cnt_q == BITS_W'(FRAME_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (words_q != 2'd0) ? S_SREQ : S_WCC;
                    end else begin
                        shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + BITS_W'(1);
                        state_d   = S_SETUP;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE; done_d = 1'b1; err_d = 2'd2;
                end
            end
            S_SREQ: begin
                if (ack_s) begin
                    stat_sh_d = {stat_sh_q[FRAME_W-2:0], confstat_s};
                    bit_cnt_d = bit_cnt_q + BITS_W'(1);
                    state_d   = S_SHOLD;
                end else if (timeout) begin
                    state_d = S_IDLE; done_d = 1'b1; err_d = 2'd1;
                end
            end
            S_SHOLD: if (cnt_q == CNT_W'(ACK_TO_NREQ - 1)) state_d = S_SNACK;
            S_SNACK: begin
                if (!ack_s) begin
                    if (bit_cnt_q == BITS_W'(FRAME_W)) begin
                        stat_valid_d = 1'b1;
                        stat_word_d  = stat_sh_q[FRAME_W-1:1];
                        stat_perr_d  = ~^stat_sh_q;
                        words_d      = words_q - 2'd1;
                        bit_cnt_d    = '0;
                        state_d      = (words_q != 2'd1) ? S_SREQ : S_WCC;
                    end else begin
                        state_d = S_SREQ;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE; done_d = 1'b1; err_d = 2'd2;
                end
            end
            S_WCC: begin
                if (complete_s) state_d = S_FIN;
                else if (timeout) begin
                    state_d = S_IDLE; done_d = 1'b1; err_d = 2'd3;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                err_d   = 2'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // One shared counter: cleared on every state entry, saturating otherwise
        if (state_d != state_q)            cnt_d = '0;
        else if (cnt_q == CNT_W'(CNT_MAX)) cnt_d = cnt_q;
        else                               cnt_d = cnt_q + CNT_W'(1);

        req_d = (state_d inside {S_REQ, S_HOLD, S_SREQ, S_SHOLD});

        if (state_d == S_IDLE)                      data_d = 1'b0;
        else if (state_d inside {S_SETUP, S_HOLD})  data_d = shift_d[FRAME_W-1];
        else                                        data_d = data_q;

        // Ready stays low during the done cycle so the next command lands after it
        cmd_ready_d = (state_d == S_IDLE) && !done_d;
    end

    always_ff @(posedge csr_aclk) begin
        if (csr_areset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            stat_sh_q    <= '0;
            bit_cnt_q    <= '0;
            words_q      <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            req_q        <= 1'b0;
            data_q       <= 1'b0;
            cmd_ready_q  <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_word_q  <= '0;
            stat_perr_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            stat_sh_q    <= stat_sh_d;
            bit_cnt_q    <= bit_cnt_d;
            words_q      <= words_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            req_q        <= req_d;
            data_q       <= data_d;
            cmd_ready_q  <= cmd_ready_d;
            stat_valid_q <= stat_valid_d;
            stat_word_q  <= stat_word_d;
            stat_perr_q  <= stat_perr_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign cmd_ready         = cmd_ready_q;
    assign stat_valid        = stat_valid_q;
    assign stat_word         = stat_word_q;
    assign stat_perr         = stat_perr_q;
    assign done              = done_q;
    assign err               = err_q;
    assign attention         = sync2_q[3];
    assign esdi_transfer_req = req_q;
    assign esdi_command_data = data_q;

endmodule

// File: tb/tb_esdi_cmd_sequencer.sv
// Directed bench for esdi_cmd_sequencer with a zero-delay ESDI drive responder.
module tb_esdi_cmd_sequencer;

    localparam int unsigned TB_TO = 60;

    logic        csr_aclk = 1'b0;
    logic        csr_areset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_word;
    logic [1:0]  cmd_nstat;
    logic        stat_valid;
    logic [15:0] stat_word;
    logic        stat_perr;
    logic        done;
    logic [1:0]  err;
    logic        attention;
    logic        esdi_transfer_req;
    logic        esdi_command_data;
    logic        esdi_transfer_ack;
    logic        esdi_confstat_data;
    logic        esdi_command_complete;
    logic        esdi_attention;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // responder controls (written by the stimulus) and observations
    bit          drv_en    = 1'b0;
    int          stall_idx = 1000;
    bit          hold_high = 1'b0;
    int          hs_cnt;
    logic [16:0] cmd_bits;
    int          low_cnt, min_low, period, rise_cyc;
    logic        prev_req;
    logic [16:0] sframe0 = {16'hA5A5, 1'b1};
    logic [16:0] sframe1 = {16'h00FF, 1'b0};

    // results gathered while waiting for done
    bit          got_done;
    logic [1:0]  done_err;
    int          done_cyc;
    int          stat_cnt;
    logic [15:0] sw [4];
    logic        sp [4];

    esdi_cmd_sequencer #(
        .DATA_SETUP (6),
        .ACK_TO_NREQ(6),
        .BIT_TIMEOUT(TB_TO)
    ) dut (
        .csr_aclk             (csr_aclk),
        .csr_areset           (csr_areset),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_word             (cmd_word),
        .cmd_nstat            (cmd_nstat),
        .stat_valid           (stat_valid),
        .stat_word            (stat_word),
        .stat_perr            (stat_perr),
        .done                 (done),
        .err                  (err),
        .attention            (attention),
        .esdi_transfer_req    (esdi_transfer_req),
        .esdi_command_data    (esdi_command_data),
        .esdi_transfer_ack    (esdi_transfer_ack),
        .esdi_confstat_data   (esdi_confstat_data),
        .esdi_command_complete(esdi_command_complete),
        .esdi_attention       (esdi_attention)
    );

    always #5 csr_aclk = ~csr_aclk;

    always @(posedge csr_aclk) cyc <= cyc + 1;

    // Drive model: acks each req rise at once, drops ack once req falls
    always @(posedge csr_aclk) begin
        #1;
        if (!drv_en) begin
            esdi_transfer_ack  = 1'b0;
            esdi_confstat_data = 1'b0;
            hs_cnt   = 0;
            low_cnt  = 0;
            min_low  = 1000;
            period   = 0;
            prev_req = 1'b0;
            cmd_bits = '0;
        end else begin
            if (esdi_transfer_req && !prev_req) begin
                if (hs_cnt > 0 && low_cnt < min_low) min_low = low_cnt;
                period   = cyc - rise_cyc;
                rise_cyc = cyc;
            end
            if (!esdi_transfer_req) low_cnt = low_cnt + 1;
            else                    low_cnt = 0;
            if (esdi_transfer_req && !esdi_transfer_ack && hs_cnt != stall_idx) begin
                if (hs_cnt < 17) begin
                    cmd_bits = {cmd_bits[15:0], esdi_command_data};
                end else begin
                    logic [16:0] sf;
                    int          j;
                    j  = hs_cnt - 17;
                    sf = (j < 17) ? sframe0 : sframe1;
                    esdi_confstat_data = sf[5'(16 - (j % 17))];
                end
                esdi_transfer_ack = 1'b1;
                hs_cnt = hs_cnt + 1;
            end else if (!esdi_transfer_req && esdi_transfer_ack && !(hold_high && hs_cnt == 1)) begin
                esdi_transfer_ack = 1'b0;
            end
            prev_req = esdi_transfer_req;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge csr_aclk);
        #1;
    endtask

    task automatic drv_restart(input int stall, input bit hold);
        drv_en = 1'b0;
        repeat (3) tick();
        stall_idx = stall;
        hold_high = hold;
        drv_en    = 1'b1;
    endtask

    task automatic send_cmd(input logic [15:0] w, input logic [1:0] n);
        int k;
        k = 0;
        while (!cmd_ready && k < 20) begin
            tick();
            k++;
        end
        check("cmd_ready_before_send", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_word  = w;
        cmd_nstat = n;
        tick();
        cmd_valid = 1'b0;
        check("cmd_ready_drop_after_accept", 32'(cmd_ready), 32'd0);
    endtask

    task automatic wait_done(input int budget);
        got_done = 1'b0;
        stat_cnt = 0;
        for (int i = 0; i < budget && !got_done; i++) begin
            tick();
            if (stat_valid) begin
                if (stat_cnt < 4) begin
                    sw[stat_cnt] = stat_word;
                    sp[stat_cnt] = stat_perr;
                end
                stat_cnt++;
            end
            if (done) begin
                got_done = 1'b1;
                done_err = err;
                done_cyc = cyc;
            end
        end
        check("done_seen", 32'(got_done), 32'd1);
    endtask

    task automatic wait_hs(input int n, input int budget);
        bit reached;
        reached = 1'b0;
        for (int i = 0; i < budget && !reached; i++) begin
            tick();
            if (hs_cnt >= n && (n < 17 || !esdi_transfer_ack)) reached = 1'b1;
        end
        check("handshake_reached", 32'(reached), 32'd1);
    endtask

    initial begin
        int early;
        csr_areset            = 1'b1;
        cmd_valid             = 1'b0;
        cmd_word              = '0;
        cmd_nstat             = '0;
        esdi_command_complete = 1'b0;
        esdi_attention        = 1'b0;
        repeat (3) tick();

        // reset state
        check("rst_req",        32'(esdi_transfer_req), 32'd0);
        check("rst_cmd_data",   32'(esdi_command_data), 32'd0);
        check("rst_cmd_ready",  32'(cmd_ready),         32'd0);
        check("rst_stat_valid", 32'(stat_valid),        32'd0);
        check("rst_stat_word",  32'(stat_word),         32'd0);
        check("rst_stat_perr",  32'(stat_perr),         32'd0);
        check("rst_done",       32'(done),              32'd0);
        check("rst_err",        32'(err),               32'd0);
        check("rst_attention",  32'(attention),         32'd0);
        csr_areset = 1'b0;
        tick();
        check("ready_after_reset", 32'(cmd_ready), 32'd1);

        // attention is only synchronised through
        esdi_attention = 1'b1;
        repeat (3) tick();
        check("attention_sync", 32'(attention), 32'd1);
        check("attention_no_fsm_effect", 32'(cmd_ready), 32'd1);
        esdi_attention = 1'b0;

        // 0x1234, no status, complete held off until the frame is out
        drv_restart(1000, 1'b0);
        send_cmd(16'h1234, 2'd0);
        wait_hs(17, 2000);
        check("t1_bits", 32'(cmd_bits), 32'h02468);
        check("t1_setup_ok", 32'(min_low >= 6), 32'd1);
        check("t1_req_low_min", 32'(min_low), 32'd9);
        check("t1_bit_period", 32'(period), 32'd18);
        early = 0;
        repeat (10) begin
            tick();
            if (done) early++;
        end
        check("t1_no_early_done", 32'(early), 32'd0);
        esdi_command_complete = 1'b1;
        wait_done(20);
        check("t1_err", 32'(done_err), 32'd0);
        tick();
        check("t1_ready_after_done", 32'(cmd_ready), 32'd1);

        // 0xFFFF: parity bit is 1
        drv_restart(1000, 1'b0);
        send_cmd(16'hFFFF, 2'd0);
        wait_done(2000);
        check("t2_hs", 32'(hs_cnt), 32'd17);
        check("t2_bits", 32'(cmd_bits), 32'h1FFFF);
        check("t2_err", 32'(done_err), 32'd0);

        // 0x0001 with two status words
        drv_restart(1000, 1'b0);
        send_cmd(16'h0001, 2'd2);
        wait_done(3000);
        check("t3_bits", 32'(cmd_bits), 32'h00002);
        check("t3_hs", 32'(hs_cnt), 32'd51);
        check("t3_stat_cnt", 32'(stat_cnt), 32'd2);
        check("t3_word0", 32'(sw[0]), 32'hA5A5);
        check("t3_perr0", 32'(sp[0]), 32'd0);
        check("t3_word1", 32'(sw[1]), 32'h00FF);
        check("t3_perr1", 32'(sp[1]), 32'd1);
        check("t3_err", 32'(done_err), 32'd0);
        check("t3_word_held", 32'(stat_word), 32'h00FF);

        // drive never acks bit 5
        drv_restart(5, 1'b0);
        send_cmd(16'h1234, 2'd0);
        wait_done(2000);
        check("t4_hs", 32'(hs_cnt), 32'd5);
        check("t4_err", 32'(done_err), 32'd1);
        check("t4_req_low", 32'(esdi_transfer_req), 32'd0);
        check("t4_latency", 32'(done_cyc - rise_cyc), 32'(TB_TO));
        tick();
        check("t4_ready", 32'(cmd_ready), 32'd1);

        // drive holds ack after bit 0
        drv_restart(1000, 1'b1);
        send_cmd(16'h1234, 2'd0);
        wait_done(500);
        check("t5_err", 32'(done_err), 32'd2);
        check("t5_req_low", 32'(esdi_transfer_req), 32'd0);
        check("t5_hs", 32'(hs_cnt), 32'd1);

        // drive never signals complete
        esdi_command_complete = 1'b0;
        drv_restart(1000, 1'b0);
        send_cmd(16'h1234, 2'd0);
        wait_done(2000);
        check("t6_err", 32'(done_err), 32'd3);
        check("t6_hs", 32'(hs_cnt), 32'd17);

        // reset while holding bit 8, then a clean command
        esdi_command_complete = 1'b1;
        drv_restart(1000, 1'b0);
        send_cmd(16'h1234, 2'd0);
        wait_hs(9, 2000);
        repeat (3) tick();
        check("t7_req_before_reset", 32'(esdi_transfer_req), 32'd1);
        csr_areset = 1'b1;
        tick();
        check("t7_req_drop", 32'(esdi_transfer_req), 32'd0);
        check("t7_no_done_in_reset", 32'(done), 32'd0);
        drv_en = 1'b0;
        tick();
        check("t7_ready_in_reset", 32'(cmd_ready), 32'd0);
        csr_areset = 1'b0;
        early = 0;
        repeat (10) begin
            tick();
            if (done) early++;
        end
        check("t7_no_done_after_reset", 32'(early), 32'd0);
        drv_restart(1000, 1'b0);
        send_cmd(16'h1234, 2'd0);
        wait_done(2000);
        check("t7_bits", 32'(cmd_bits), 32'h02468);
        check("t7_err", 32'(done_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
